first_layer_synapse_sequencer: RTL and testbench

- Walks first-layer neurons 0..NEURON_NUM-1.
- For each neuron, reads the per-neuron synapse start offset from the first-layer offset memory. That memory has a 1-cycle registered read and a 10-bit offset word.
- Streams the neuron's synapse indices [offset[n], offset[n+1]) to the downstream weight/accumulate stage over a valid/ready handshake.
- The last neuron's end bound is the parameter TOTAL_SYN.
- Reuses each hi bound as the next neuron's lo bound, so each neuron costs one memory read.

---
 rtl/snn_seq_pkg.sv | 19 +
 rtl/first_layer_synapse_sequencer.sv | 151 +++++++++++++++
 tb/tb_first_layer_synapse_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snn_seq_pkg.sv
// Shared types and widths for the first-layer synapse sequencer.
package snn_seq_pkg;

   // Neuron index width (up to 64 neurons) and default synapse index width.
   localparam int NEURON_IDX_W   = 6;
   localparam int DEFAULT_ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PRIME      = 3'd1,
      CAP_LO     = 3'd2,
      CAP_HI     = 3'd3,
      STREAM     = 3'd4,
      NEURON_END = 3'd5,
      WAIT       = 3'd6,
      DONE       = 3'd7
   } state_t;

endpackage

// File: rtl/first_layer_synapse_sequencer.sv
// Walks first-layer neurons, fetches each neuron's synapse start offset from a
// registered-read offset memory and streams that neuron's synapse indices
// [lo, hi) downstream over valid/ready. Each hi bound becomes the next lo, so
// every neuron costs exactly one memory read.
module first_layer_synapse_sequencer
   import snn_seq_pkg::*;
#(
   parameter int NEURON_NUM = 40,
   parameter int ADDR_W     = DEFAULT_ADDR_W,
   parameter int TOTAL_SYN  = 1024
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    abort,
   output logic [NEURON_IDX_W-1:0] offset_addr,
   input  logic [ADDR_W-1:0]       offset_data,
   output logic                    syn_valid,
   input  logic                    syn_ready,
   output logic [ADDR_W-1:0]       syn_addr,
   output logic [NEURON_IDX_W-1:0] syn_neuron,
   output logic                    syn_last,
   output logic                    neuron_done,
   output logic                    done,
   output logic                    busy,
   output logic                    err
);

   // ptr/end carry one extra bit so an exclusive end of 2**ADDR_W fits.
   localparam int PW = ADDR_W + 1;
   localparam logic [NEURON_IDX_W-1:0] LAST_N    = NEURON_IDX_W'(NEURON_NUM - 1);
   localparam logic [PW-1:0]           TOTAL_END = PW'(TOTAL_SYN);

   state_t                  state_r;
   logic [NEURON_IDX_W-1:0] n_r;
   logic [PW-1:0]           ptr_r;
   logic [PW-1:0]           end_r;

   logic [PW-1:0]           hi_s;
   logic [NEURON_IDX_W:0]   n_plus2_s;

   // The last neuron's upper bound is the fixed total, not a memory word.
   assign hi_s      = (n_r == LAST_N) ? TOTAL_END : {1'b0, offset_data};
   assign n_plus2_s = {1'b0, n_r} + (NEURON_IDX_W + 1)'(2);

   // Handshake and pulse outputs decode straight from the state register.
   assign syn_valid   = (state_r == STREAM);
   assign neuron_done = (state_r == NEURON_END);
   assign done        = (state_r == DONE);
   assign syn_addr    = ptr_r[ADDR_W-1:0];
   assign syn_neuron  = n_r;

   // Sequencer FSM with the neuron counter, lo/hi bounds and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= IDLE;
         n_r         <= '0;
         ptr_r       <= '0;
         end_r       <= '0;
         offset_addr <= '0;
         syn_last    <= 1'b0;
         busy        <= 1'b0;
         err         <= 1'b0;
      end else if (abort) begin
         // Abort wins over start and over any transfer presented this cycle.
         state_r  <= IDLE;
         syn_last <= 1'b0;
         busy     <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (start) begin
                  offset_addr <= '0;
                  n_r         <= '0;
                  err         <= 1'b0;
                  busy        <= 1'b1;
                  state_r     <= PRIME;
               end else begin
                  state_r <= IDLE;
               end
            end
            PRIME: begin
               // Address 0 is sampled now; queue address 1 behind it.
               offset_addr <= NEURON_IDX_W'(1);
               state_r     <= CAP_LO;
            end
            CAP_LO: begin
               ptr_r   <= {1'b0, offset_data};
               state_r <= CAP_HI;
            end
            CAP_HI: begin
               end_r <= hi_s;
               if (hi_s <= ptr_r) begin
                  // Empty neuron; a hi below lo is a malformed table.
                  if (hi_s < ptr_r) begin
                     err <= 1'b1;
                  end else begin
                     err <= err;
                  end
                  syn_last <= 1'b0;
                  state_r  <= NEURON_END;
               end else begin
                  syn_last <= ((ptr_r + PW'(1)) == hi_s);
                  state_r  <= STREAM;
               end
            end
            STREAM: begin
               if (syn_ready) begin
                  ptr_r <= ptr_r + PW'(1);
                  if (syn_last) begin
                     syn_last <= 1'b0;
                     state_r  <= NEURON_END;
                  end else begin
                     syn_last <= ((ptr_r + PW'(2)) == end_r);
                     state_r  <= STREAM;
                  end
               end else begin
                  state_r <= STREAM;
               end
            end
            NEURON_END: begin
               // Hi becomes next lo even when the neuron was malformed.
               ptr_r <= end_r;
               if (n_r == LAST_N) begin
                  state_r <= DONE;
               end else begin
                  n_r <= n_r + NEURON_IDX_W'(1);
                  if (n_plus2_s <= {1'b0, LAST_N}) begin
                     offset_addr <= n_plus2_s[NEURON_IDX_W-1:0];
                  end else begin
                     offset_addr <= offset_addr;
                  end
                  state_r <= WAIT;
               end
            end
            WAIT: begin
               state_r <= CAP_HI;
            end
            DONE: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_first_layer_synapse_sequencer.sv
// Bench: four sequencer instances with different layer shapes, each fed by a
// registered-read offset memory. A queue-based model lists every expected
// transfer / neuron_done / done event in order; one negedge process checks
// the active instance against it.
module tb_first_layer_synapse_sequencer;

   localparam int NI = 4;

   function automatic int nn_of(input int g);
      case (g)
         0:       return 2;
         1, 2:    return 3;
         default: return 40;
      endcase
   endfunction

   function automatic int ts_of(input int g);
      case (g)
         0:       return 5;
         1:       return 2;
         2:       return 6;
         default: return 1024;
      endcase
   endfunction

   typedef struct {
      int kind;     // 0 transfer, 1 neuron_done, 2 done
      int addr;
      int neuron;
      bit last;
   } ev_t;

   logic       clk;
   logic       rst_n;
   logic       start_s     [NI];
   logic       abort_s     [NI];
   logic       syn_ready_s [NI];
   logic [5:0] oa [NI];
   logic [9:0] od [NI];
   logic       sv [NI];
   logic [9:0] sa [NI];
   logic [5:0] sn [NI];
   logic       sl [NI];
   logic       nd [NI];
   logic       dn [NI];
   logic       bz [NI];
   logic       er [NI];
   logic [9:0] mem [NI][64];

   ev_t ev_q[$];
   int  n_assert = 0;
   int  n_fail   = 0;
   int  cur      = 0;
   bit  chk_en   = 0;
   int  busy_cnt = 0;
   int  xfer_cnt = 0;
   bit  err_exp  = 0;
   int  bc;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      first_layer_synapse_sequencer #(
         .NEURON_NUM (nn_of(g)),
         .ADDR_W     (10),
         .TOTAL_SYN  (ts_of(g))
      ) dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .start       (start_s[g]),
         .abort       (abort_s[g]),
         .offset_addr (oa[g]),
         .offset_data (od[g]),
         .syn_valid   (sv[g]),
         .syn_ready   (syn_ready_s[g]),
         .syn_addr    (sa[g]),
         .syn_neuron  (sn[g]),
         .syn_last    (sl[g]),
         .neuron_done (nd[g]),
         .done        (dn[g]),
         .busy        (bz[g]),
         .err         (er[g])
      );
   end

   // Offset memories: one-cycle registered read.
   always @(posedge clk) begin
      for (int g = 0; g < NI; g++) od[g] <= mem[g][oa[g]];
   end

   task automatic chk(input string name, input longint act, input longint exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic longint enc(input int a, input int n, input bit l);
      return longint'(a) * 1000 + longint'(n) * 10 + longint'(l);
   endfunction

   function automatic longint pack_outs(input int g);
      return longint'({oa[g], sv[g], sa[g], sn[g], sl[g], nd[g], dn[g], bz[g], er[g]});
   endfunction

   // Expected event list straight from the offset table.
   task automatic build_model(input int g);
      int lo, hi, nn;
      nn = nn_of(g);
      ev_q.delete();
      err_exp = 1'b0;
      lo = int'(mem[g][0]);
      for (int n = 0; n < nn; n++) begin
         hi = (n == nn - 1) ? ts_of(g) : int'(mem[g][n + 1]);
         if (hi < lo) err_exp = 1'b1;
         for (int a = lo; a < hi; a++) ev_q.push_back('{0, a, n, (a == hi - 1)});
         ev_q.push_back('{1, 0, n, 1'b0});
         lo = hi;
      end
      ev_q.push_back('{2, 0, 0, 1'b0});
   endtask

   function automatic int count_kind(input int k);
      int c = 0;
      foreach (ev_q[i]) if (ev_q[i].kind == k) c++;
      return c;
   endfunction

   // Cycle-by-cycle comparison of the active instance against the model.
   always @(negedge clk) begin
      longint exp_v;
      if (chk_en) begin
         chk("offset_addr_range", longint'(oa[cur] <= 6'(nn_of(cur) - 1)), 1);
         if (bz[cur]) busy_cnt++;
         if (sv[cur]) begin
            exp_v = (ev_q.size() > 0 && ev_q[0].kind == 0) ?
                    enc(ev_q[0].addr, ev_q[0].neuron, ev_q[0].last) : -1;
            chk("syn_xfer", enc(int'(sa[cur]), int'(sn[cur]), sl[cur]), exp_v);
            if (exp_v >= 0 && syn_ready_s[cur] && !abort_s[cur]) begin
               void'(ev_q.pop_front());
               xfer_cnt++;
            end
         end
         if (nd[cur]) begin
            exp_v = (ev_q.size() > 0 && ev_q[0].kind == 1) ? ev_q[0].neuron : -1;
            chk("neuron_done", longint'(sn[cur]), exp_v);
            if (exp_v >= 0) void'(ev_q.pop_front());
         end
         if (dn[cur]) begin
            exp_v = (ev_q.size() > 0) ? ev_q[0].kind : -1;
            chk("done_order", exp_v, 2);
            if (exp_v == 2) void'(ev_q.pop_front());
         end
      end
   end

   // One full pass: rmode 0 ready=1, 1 ready toggles, 2 random ready + stray starts.
   task automatic run_pass(input int g, input int rmode, output int bcyc);
      int cyc;
      cur = g;
      build_model(g);
      busy_cnt = 0;
      xfer_cnt = 0;
      chk_en = 1'b1;
      syn_ready_s[g] = 1'b1;
      start_s[g] = 1'b1;
      @(posedge clk); #1;
      start_s[g] = 1'b0;
      chk("err_cleared_on_start", longint'(er[g]), 0);
      cyc = 0;
      while (ev_q.size() > 0 && cyc < 20000) begin
         case (rmode)
            0:       syn_ready_s[g] = 1'b1;
            1:       syn_ready_s[g] = (cyc % 2 == 0);
            default: syn_ready_s[g] = 1'($urandom_range(0, 1));
         endcase
         start_s[g] = (rmode == 2 && cyc % 97 == 50);
         @(posedge clk); #1;
         cyc++;
      end
      start_s[g] = 1'b0;
      syn_ready_s[g] = 1'b1;
      chk("pass_complete_events_left", ev_q.size(), 0);
      @(negedge clk);
      chk("idle_after_pass", longint'(bz[g]), 0);
      chk("err_final", longint'(er[g]), longint'(err_exp));
      bcyc = busy_cnt;
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int prev, v, cyc;
      rst_n = 1'b0;
      for (int g = 0; g < NI; g++) begin
         start_s[g] = 1'b0;
         abort_s[g] = 1'b0;
         syn_ready_s[g] = 1'b0;
         for (int i = 0; i < 64; i++) mem[g][i] = 10'd0;
      end
      mem[0][0] = 10'd0; mem[0][1] = 10'd3;
      mem[1][0] = 10'd0; mem[1][1] = 10'd0; mem[1][2] = 10'd2;
      mem[2][0] = 10'd4; mem[2][1] = 10'd2; mem[2][2] = 10'd5;
      prev = int'($urandom_range(0, 20));
      mem[3][0] = 10'(prev);
      for (int i = 1; i < 40; i++) begin
         if ($urandom_range(0, 9) == 0) v = prev - int'($urandom_range(0, 5));
         else v = prev + int'($urandom_range(0, 30));
         if (v < 0) v = 0;
         if (v > 1023) v = 1023;
         mem[3][i] = 10'(v);
         prev = v;
      end

      repeat (3) @(posedge clk);
      #1;
      for (int g = 0; g < NI; g++) chk("reset_outputs", pack_outs(g), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Test 1: pin the model, then a ready=1 pass.
      build_model(0);
      chk("model_t1_events", ev_q.size(), 8);
      chk("model_t1_n0_last", enc(ev_q[2].addr, ev_q[2].neuron, ev_q[2].last), 2001);
      chk("model_t1_n1_last", enc(ev_q[5].addr, ev_q[5].neuron, ev_q[5].last), 4011);
      run_pass(0, 0, bc);
      chk("t1_busy_cycles", bc, 13);
      chk("t1_transfers", xfer_cnt, 5);

      // Test 2: ready toggling.
      run_pass(0, 1, bc);
      chk("t2_transfers", xfer_cnt, 5);

      // Test 3: empty neurons, no error.
      build_model(1);
      chk("model_t3_transfers", count_kind(0), 2);
      chk("model_t3_err", longint'(err_exp), 0);
      run_pass(1, 0, bc);
      chk("t3_transfers", xfer_cnt, 2);

      // Test 4: malformed table, sticky err until the next start.
      build_model(2);
      chk("model_t4_transfers", count_kind(0), 4);
      chk("model_t4_err", longint'(err_exp), 1);
      run_pass(2, 2, bc);
      repeat (3) @(posedge clk);
      #1;
      chk("t4_err_sticky", longint'(er[2]), 1);
      run_pass(2, 0, bc);

      // Test 5: abort after two transfers, then replay.
      cur = 0;
      build_model(0);
      xfer_cnt = 0;
      chk_en = 1'b1;
      syn_ready_s[0] = 1'b1;
      start_s[0] = 1'b1;
      @(posedge clk); #1;
      start_s[0] = 1'b0;
      cyc = 0;
      while (xfer_cnt < 2 && cyc < 100) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("t5_reached_two_transfers", xfer_cnt, 2);
      abort_s[0] = 1'b1;
      @(posedge clk); #1;
      abort_s[0] = 1'b0;
      ev_q.delete();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("t5_idle_after_abort", longint'({bz[0], dn[0], sv[0]}), 0);
      end
      @(posedge clk); #1;
      run_pass(0, 0, bc);
      chk("t5_replay_busy_cycles", bc, 13);

      // Test 6: reset in CAP_HI, then a random N=40 pass with stray starts.
      cur = 3;
      build_model(3);
      chk_en = 1'b1;
      start_s[3] = 1'b1;
      @(posedge clk); #1;
      start_s[3] = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t6_reset_mid_pass", pack_outs(3), 0);
      ev_q.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_pass(3, 2, bc);
      build_model(3);
      chk("t6_all_transfers", xfer_cnt, count_kind(0));
      ev_q.delete();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
